// File: rtl/axis_outbuf_pkg.sv
// Shared definitions for the axis_outbuf writer and reader sides: bank count,
// bank-select width and the reader state encoding.
package axis_outbuf_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int BANK_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_SEL_W-1:0] sel);
        logic [NUM_BANKS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO holding {tuser, tlast, tdata} beats between the buffer read
// port and the AXI-stream output. Push into a full FIFO is only accepted with a pop.
module axis_skid_fifo2 #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_reg[gi] <= '0;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/axis_outbuf_reader.sv
// Drains the 4-bank output buffer round-robin onto an AXI-stream master port.
// Optional stall counter enabled by defining AXIS_OUTBUF_RD_PERF_EN.
module axis_outbuf_reader
    import axis_outbuf_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int LINE_LEN    = 32,
    parameter int FRAME_LINES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_BANKS-1:0]  bank_full,
    output logic [NUM_BANKS-1:0]  bank_release,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [BANK_SEL_W-1:0] rcs,
    output logic                  re,
    input  logic [DATA_WIDTH-1:0] rdout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [31:0]           stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int LC_W  = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int FW    = DATA_WIDTH + 2;
    localparam logic [PTR_W-1:0] LINE_END  = PTR_W'(LINE_LEN);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(LINE_LEN - 1);
    localparam logic [LC_W-1:0]  LAST_LINE = LC_W'(FRAME_LINES - 1);

    rd_state_t             state_reg, state_next;
    logic [BANK_SEL_W-1:0] cur_bank_reg, cur_bank_next, bank_after;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [LC_W-1:0]       line_cnt_reg, line_cnt_next;
    logic [NUM_BANKS-1:0]  bank_release_reg, bank_release_next;
    logic                  inflight_reg, infl_last_reg, infl_user_reg;
    logic                  re_c, line_end_c, pop, credit_ok;

    logic [FW-1:0] fifo_head;
    logic [1:0]    fifo_count;
    logic          fifo_full, fifo_empty;

    axis_skid_fifo2 #(.WIDTH(FW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data ({infl_user_reg, infl_last_reg, rdout}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = fifo_head[DATA_WIDTH];
    assign m_axis_tuser  = fifo_head[DATA_WIDTH+1];
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign bank_after    = cur_bank_reg + BANK_SEL_W'(1);

    // Issue a read while fifo_count + inflight stays below 2, counting the slot
    // freed by a same-cycle pop so a ready sink sees one pixel per cycle.
    assign credit_ok = fifo_full ? pop : (fifo_empty || !inflight_reg || pop);

    always_comb begin
        state_next        = state_reg;
        cur_bank_next     = cur_bank_reg;
        rd_ptr_next       = rd_ptr_reg;
        line_cnt_next     = line_cnt_reg;
        bank_release_next = '0;
        re_c              = 1'b0;
        line_end_c        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bank_full[cur_bank_reg]) state_next = STREAM;
            end
            STREAM: begin
                if (credit_ok && (rd_ptr_reg < LINE_END)) begin
                    re_c        = 1'b1;
                    rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                    if (rd_ptr_reg == LAST_IDX) state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The tlast beat is the only one left; the line ends on its handshake edge.
                if (pop && m_axis_tlast && (fifo_count == 2'd1) && !inflight_reg)
                    line_end_c = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (line_end_c) begin
            bank_release_next = bank_onehot(cur_bank_reg);
            cur_bank_next     = bank_after;
            rd_ptr_next       = '0;
            line_cnt_next     = (line_cnt_reg == LAST_LINE) ? '0 : line_cnt_reg + LC_W'(1);
            state_next        = bank_full[bank_after] ? STREAM : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cur_bank_reg     <= '0;
            rd_ptr_reg       <= '0;
            line_cnt_reg     <= '0;
            bank_release_reg <= '0;
            inflight_reg     <= 1'b0;
            infl_last_reg    <= 1'b0;
            infl_user_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cur_bank_reg     <= cur_bank_next;
            rd_ptr_reg       <= rd_ptr_next;
            line_cnt_reg     <= line_cnt_next;
            bank_release_reg <= bank_release_next;
            inflight_reg     <= re_c;
            if (re_c) begin
                infl_last_reg <= (rd_ptr_reg == LAST_IDX);
                infl_user_reg <= (rd_ptr_reg == '0) && (line_cnt_reg == '0);
            end
        end
    end

    assign re           = re_c;
    assign raddr        = ADDR_WIDTH'(rd_ptr_reg);
    assign rcs          = cur_bank_reg;
    assign bank_release = bank_release_reg;

`ifdef AXIS_OUTBUF_RD_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_outbuf_reader.sv
// Scoreboard bench for axis_outbuf_reader: a line-level reference model queues
// expected beats and bank releases; a monitor compares what the DUT emits.
`timescale 1ns/1ps
module tb_axis_outbuf_reader;

    localparam int DW = 24, AW = 32, DEPTH = 32, LL = 4, FL = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        int            pix;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    bank_full;
    logic [3:0]    bank_release;
    logic [AW-1:0] raddr;
    logic [1:0]    rcs;
    logic          re;
    logic [DW-1:0] rdout = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [31:0]   stall_cnt;

    axis_outbuf_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LINE_LEN(LL), .FRAME_LINES(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bank_full(bank_full), .bank_release(bank_release),
        .raddr(raddr), .rcs(rcs), .re(re), .rdout(rdout),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cycle = 0;
    int fill_cnt [4] = '{0, 0, 0, 0};
    int rel_cnt  [4] = '{0, 0, 0, 0};
    int hs_total = 0, re_total = 0, exp_stall = 0, stall_base = 0;
    int mode = 0;
    bit gapless = 1'b0;

    logic [DW-1:0] mem [4][DEPTH];
    beat_t         exp_q[$];
    logic [3:0]    rel_q[$];
    bit            staged [4] = '{0, 0, 0, 0};
    logic [DW-1:0] stage_data [4][LL];
    int            next_serve = 0, model_line = 0, fill_ptr = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Writer handshake: a bank is full between a fill and its matching release.
    always_comb begin
        for (int k = 0; k < 4; k++) bank_full[k] = (fill_cnt[k] != rel_cnt[k]);
    end

    // Buffer read port with one cycle of latency.
    always @(posedge clk) if (re) rdout <= mem[rcs][raddr[4:0]];

    initial begin : tready_drv
        int idx;
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0: m_axis_tready = 1'b1;
                1: begin m_axis_tready = pat[idx]; idx = (idx + 1) % 6; end
                2: m_axis_tready = ($urandom_range(0, 3) != 0);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: lines leave in bank order 0,1,2,3,... once staged.
    task automatic advance_model();
        beat_t b;
        logic [3:0] oh;
        while (staged[next_serve]) begin
            for (int i = 0; i < LL; i++) begin
                b.data = stage_data[next_serve][i];
                b.last = (i == LL - 1);
                b.user = (i == 0) && (model_line % FL == 0);
                b.pix  = i;
                exp_q.push_back(b);
            end
            oh = 4'(1 << next_serve);
            rel_q.push_back(oh);
            staged[next_serve] = 1'b0;
            next_serve = (next_serve + 1) % 4;
            model_line++;
        end
    endtask

    task automatic fill_bank(input int k, input bit use_seq, input int base);
        int t;
        logic [DW-1:0] v;
        t = 0;
        while (bank_full[k] && t < 2000) begin @(negedge clk); t++; end
        chk("fill_wait_bank_busy", longint'(bank_full[k]), 0);
        @(negedge clk);
        for (int i = 0; i < LL; i++) begin
            v = use_seq ? DW'(base + i) : DW'($urandom);
            mem[k][i] = v;
            stage_data[k][i] = v;
        end
        fill_cnt[k] = fill_cnt[k] + 1;
        staged[k] = 1'b1;
        advance_model();
    endtask

    task automatic fill_next(input bit use_seq, input int base);
        fill_bank(fill_ptr, use_seq, base);
        fill_ptr = (fill_ptr + 1) % 4;
    endtask

    task automatic check_latency(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_axis_tvalid && n < 20);
        chk(name, n, 3);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rel_q.size() != 0) && t < 3000) begin @(negedge clk); t++; end
        chk(name, exp_q.size() + rel_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tdata"}, m_axis_tdata, 0);
        chk({tag, "_tlast_tuser"}, {m_axis_tlast, m_axis_tuser}, 0);
        chk({tag, "_re"}, re, 0);
        chk({tag, "_raddr_rcs"}, {raddr, rcs}, 0);
        chk({tag, "_bank_release"}, bank_release, 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    task automatic check_stall(input string name);
        longint want;
`ifdef AXIS_OUTBUF_RD_PERF_EN
        want = exp_stall - stall_base;
`else
        want = 0;
`endif
        chk(name, stall_cnt, want);
    endtask

    initial begin : monitor
        beat_t e;
        logic [DW+1:0] prev;
        logic [3:0] er;
        bit prev_stall;
        int last_hs, last_tlast;
        prev_stall = 1'b0; prev = '0; last_hs = -100; last_tlast = -100;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev_stall = 1'b0; continue; end
            if (re) begin
                re_total++;
                checks++;
                if (!bank_full[rcs] || raddr >= AW'(LL)) begin
                    errors++;
                    $display("FAIL read_legal: bank %0d full=%b addr %0d (required full bank, addr < %0d)",
                             rcs, bank_full[rcs], raddr, LL);
                end
            end
            if (prev_stall) begin
                checks++;
                if (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser} != prev) begin
                    errors++;
                    $display("FAIL hold: tvalid %b beat %h (required tvalid 1 beat %h)",
                             m_axis_tvalid, {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev);
                end
            end
            if (m_axis_tvalid && !m_axis_tready) exp_stall++;
            if (m_axis_tvalid && m_axis_tready) begin
                hs_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected data %h last %b user %b (required none)",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} != {e.data, e.last, e.user}) begin
                        errors++;
                        $display("FAIL beat pix %0d: got data %h last %b user %b, required data %h last %b user %b",
                                 e.pix, m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
                    end
                    if (gapless && e.pix > 0) begin
                        checks++;
                        if (cycle != last_hs + 1) begin
                            errors++;
                            $display("FAIL gapless: beat pix %0d at cycle %0d, required cycle %0d",
                                     e.pix, cycle, last_hs + 1);
                        end
                    end
                    if (e.last) last_tlast = cycle;
                end
                last_hs = cycle;
            end
            if (bank_release != 4'b0000) begin
                for (int k = 0; k < 4; k++) if (bank_release[k]) rel_cnt[k] = rel_cnt[k] + 1;
                checks++;
                er = (rel_q.size() != 0) ? rel_q.pop_front() : 4'b0000;
                if (bank_release != er || cycle != last_tlast + 1) begin
                    errors++;
                    $display("FAIL release: got %b at cycle %0d, required %b at cycle %0d",
                             bank_release, cycle, er, last_tlast + 1);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (required completion)");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0, h0, t;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        #2 rst_n = 1'b1;

        // Only bank1 full: the reader must stay on bank0.
        r0 = re_total; h0 = hs_total;
        fill_bank(1, 1'b0, 0);
        repeat (8) @(negedge clk);
        chk("bank1_only_re", re_total - r0, 0);
        chk("bank1_only_beats", hs_total - h0, 0);
        fill_bank(0, 1'b1, 10);
        check_latency("latency_bank0");
        wait_drain("drain_first");
        fill_ptr = 2;

        // All four banks full: gapless lines, releases in order.
        gapless = 1'b1;
        for (int i = 0; i < 4; i++) fill_next(1'b0, 0);
        wait_drain("drain_all4");
        gapless = 1'b0;

        // Toggling backpressure.
        mode = 1;
        fill_next(1'b0, 0);
        fill_next(1'b0, 0);
        wait_drain("drain_toggle");
        mode = 0;
        repeat (3) @(negedge clk);
        check_stall("stall_toggle");

        // Sink held off from stream start: only two reads may issue.
        mode = 3;
        repeat (2) @(negedge clk);
        r0 = re_total;
        fill_next(1'b0, 0);
        repeat (12) @(negedge clk);
        chk("hold_off_reads", re_total - r0, 2);
        mode = 0;
        wait_drain("drain_hold");

        // Random fills and random backpressure.
        mode = 2;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            fill_next(1'b0, 0);
        end
        wait_drain("drain_random");
        mode = 0;
        repeat (3) @(negedge clk);
        check_stall("stall_random");

        // Reset in the middle of a line.
        h0 = hs_total; t = 0;
        fill_next(1'b0, 0);
        while (hs_total < h0 + 2 && t < 200) begin @(negedge clk); #1; t++; end
        chk("reset_mid_line_reached", hs_total - h0 >= 2, 1);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_mid");
        exp_q.delete();
        rel_q.delete();
        for (int k = 0; k < 4; k++) begin staged[k] = 1'b0; fill_cnt[k] = rel_cnt[k]; end
        next_serve = 0; model_line = 0; fill_ptr = 0; stall_base = exp_stall;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        fill_next(1'b1, 100);
        check_latency("latency_after_reset");
        wait_drain("drain_after_reset");
        repeat (4) @(negedge clk);
        check_stall("stall_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_outbuf_reader.md
Name: axis_outbuf_reader

Overview:
- AXI-stream master that drains the 4-bank output buffer (`axis_outbuf`) onto the outbound video stream.
- Serves banks round-robin 0→1→2→3→0. Each bank holds one line of `LINE_LEN` pixels.
- Drives the buffer's read channel (`raddr`/`rcs`/`re`) and accounts for its 1-cycle read latency.
- Emits `tlast` per line and `tuser` per frame start, then hands each bank back to the writer.

Parameters:
- `DATA_WIDTH`, 24, pixel width; equals the buffer data width.
- `ADDR_WIDTH`, 32, buffer address width.
- `DEPTH`, 32, words per bank.
- `LINE_LEN`, 32, pixels per line; 1 ≤ `LINE_LEN` ≤ `DEPTH`.
- `FRAME_LINES`, 4, lines per frame; sets `tuser` placement.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `bank_full`  in  4  level; bank k holds a complete line. Writer clears it after `bank_release[k]`.
- `bank_release`  out  4  one-cycle pulse; bank k fully consumed.
- `raddr`  out  `ADDR_WIDTH`  buffer read address.
- `rcs`  out  2  buffer bank select.
- `re`  out  1  buffer read enable.
- `rdout`  in  `DATA_WIDTH`  buffer read data; valid in the cycle after `re`.
- `m_axis_tdata`  out  `DATA_WIDTH`  pixel.
- `m_axis_tvalid`  out  1  data valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last pixel of line.
- `m_axis_tuser`  out  1  first pixel of frame.
- `stall_cnt`  out  32  backpressure counter (see Optional Feature).

Behaviour:
- Reset (async, `rst_n`=0): all outputs 0; state `IDLE`; `cur_bank`=0; `rd_ptr`=0; `line_cnt`=0; FIFO empty; no read in flight.
- Reset mid-line abandons the line. No `bank_release` is issued; the writer is reset by the same `rst_n`.
- State `IDLE`: waits for `bank_full[cur_bank]`=1, then goes to `STREAM`. Other banks' `bank_full` bits are ignored.
- State `STREAM`:
  - `re`=1 when (fifo_count + inflight) < 2 and `rd_ptr` < `LINE_LEN`.
  - `raddr` = `rd_ptr`; `rcs` = `cur_bank`; `rd_ptr` increments on each `re`.
  - `inflight` is set by `re` and cleared the next cycle, when `rdout` is pushed into the 2-entry FIFO.
  - When `rd_ptr` reaches `LINE_LEN`, go to `DRAIN`.
- State `DRAIN`: waits until the FIFO is empty, no read is in flight, and the `tlast` beat has handshaken.
- Line end:
  - Pulse `bank_release[cur_bank]` one cycle.
  - `cur_bank` += 1 mod 4; `rd_ptr` = 0.
  - `line_cnt` += 1, wrapping to 0 at `FRAME_LINES`.
  - Go to `IDLE`; if the next bank is already full, go to `STREAM` on the same edge (zero bubble).
- Latency: `bank_full` sampled high at edge N → `re` high in cycle N+1 → `m_axis_tvalid` high in cycle N+3.
- Throughput: 1 pixel/cycle sustained while `tready`=1.
- AXIS rules:
  - `tvalid`, `tdata`, `tlast` and `tuser` come from the FIFO head.
  - They are held stable while `tvalid` && !`tready`.
  - `tvalid` never drops without a handshake.
- `tlast` = 1 on the beat with pixel index `LINE_LEN`-1.
- `tuser` = 1 on pixel 0 when `line_cnt`=0.
- Backpressure: the FIFO never overflows; the credit rule guarantees that the in-flight datum always has a free slot.
- Never reads a bank whose `bank_full`=0. Never reads beyond `LINE_LEN`-1.
- `LINE_LEN`=1: `re` issues once; the single beat carries `tlast`=1.

Optional Feature:
- Macro `AXIS_OUTBUF_RD_PERF_EN`.
- Defined: `stall_cnt` increments (saturating at 2^32-1) on every cycle with `tvalid`=1 and `tready`=0. Reset to 0.
- Undefined: `stall_cnt` is tied to 0 and the counter logic is absent.

Decomposition:
- Package `axis_outbuf_pkg`:
  - `NUM_BANKS`=4, `BANK_SEL_W`=2.
  - State enum `IDLE`/`STREAM`/`DRAIN`.
  - Shared with the writer side.
- Sub-module `axis_skid_fifo2`: 2-entry FIFO carrying {`tuser`,`tlast`,`tdata`}, exposing count, push, pop and full/empty.

Test Plan (`LINE_LEN`=4, `FRAME_LINES`=2):
- `bank_full`=4'b0001, `tready`=1, bank0 = 10..13 → `tdata` 10,11,12,13 on consecutive cycles. First `tvalid` 3 cycles after `bank_full`; `tuser` on 10, `tlast` on 13; `bank_release`=4'b0001 one cycle after the 13 handshake.
- All four banks full → 16 beats with no bubbles; `tuser` on beats 0 and 8; `bank_release` pulses 0,1,2,3 in order.
- `tready` toggled 1,0,0,1,0,1… → data sequence intact, no drop or duplicate, `tdata` stable during stalls; `stall_cnt` equals the number of stalled cycles with the macro, 0 without.
- Only `bank_full[1]`=1 at start → no `re` and no `tvalid` until `bank_full[0]` asserts.
- `rst_n` pulsed low after 2 beats → all outputs 0 immediately; after release, restarts at bank0 with `tuser`=1 and no `bank_release` for the aborted line.
- `tready`=0 for 10 cycles from stream start → exactly 2 `re` issued; `re` stays low until the FIFO drains.
